// File: rtl/result_demux4_pkg.sv
// Shared constants for the result demultiplexer: port index encodings,
// default widths and the select-decode helper used by the top level.
// Latency: none (package). Backpressure: n/a.
package result_demux4_pkg;

    // Destination port indices as carried on sel.
    localparam logic [1:0] SEL_PORT0 = 2'd0;
    localparam logic [1:0] SEL_PORT1 = 2'd1;
    localparam logic [1:0] SEL_PORT2 = 2'd2;
    localparam logic [1:0] SEL_PORT3 = 2'd3;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_COUNT_W = 16;

    // One-hot decode of a destination index.
    function automatic logic [3:0] sel_onehot(input logic [1:0] s);
        logic [3:0] oh;
        oh = 4'b0000;
        case (s)
            SEL_PORT0: oh = 4'b0001;
            SEL_PORT1: oh = 4'b0010;
            SEL_PORT2: oh = 4'b0100;
            default:   oh = 4'b1000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/result_demux4_slot.sv
// One-entry holding slot for a single demux destination, with optional drain counter.
// Latency: word loaded at edge N is on o_dat with o_vld=1 right after edge N.
// Backpressure: slot holds its word while !i_rdy; a same-cycle drain and load keeps it FULL.
//
// Ports: clk/rst (async active-high), i_load (write enable from the top),
// i_dat (word to store), i_rdy (destination takes the word), o_vld (slot FULL),
// o_dat (slot contents, held when EMPTY), o_cnt (drain count, RESULT_DEMUX4_COUNT_EN only).
module demux_slot #(
    parameter int WIDTH   = 32
`ifdef RESULT_DEMUX4_COUNT_EN
    ,
    parameter int COUNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_dat,
    input  logic             i_rdy,
    output logic             o_vld,
    output logic [WIDTH-1:0] o_dat
`ifdef RESULT_DEMUX4_COUNT_EN
    ,
    output logic [COUNT_W-1:0] o_cnt
`endif
);

    logic             r_vld;
    logic [WIDTH-1:0] r_dat;
    logic             w_drain;

    assign w_drain = r_vld && i_rdy;

    // Load wins over drain: a simultaneous drain+refill leaves the slot FULL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= 1'b0;
            r_dat <= '0;
        end else if (i_load) begin
            r_vld <= 1'b1;
            r_dat <= i_dat;
        end else if (w_drain) begin
            r_vld <= 1'b0;
        end
    end

`ifdef RESULT_DEMUX4_COUNT_EN
    logic [COUNT_W-1:0] r_cnt;

    // Free-running wrap at 2^COUNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_drain) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
`endif

    assign o_vld = r_vld;
    assign o_dat = r_dat;

endmodule

// File: rtl/result_demux4.sv
// Registered 1-to-4 result demux: steers one producer stream to four independent one-entry slots.
// Latency: one registered stage; accepted word is visible on its port right after the accepting edge.
// Backpressure: in_ready follows only the selected slot, so a stalled port never blocks the others.
//
// Ports: clk/rst (async active-high), in_valid/in_ready/in_data/sel (producer side),
// out_valid[3:0]/out_ready[3:0]/out_data0..3 (destination side),
// xfer_cnt0..3 (per-port completed drains, present only with RESULT_DEMUX4_COUNT_EN defined).
module result_demux4
    import result_demux4_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH
`ifdef RESULT_DEMUX4_COUNT_EN
    ,
    parameter int COUNT_W = DEF_COUNT_W
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       sel,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3
`ifdef RESULT_DEMUX4_COUNT_EN
    ,
    output logic [COUNT_W-1:0] xfer_cnt0,
    output logic [COUNT_W-1:0] xfer_cnt1,
    output logic [COUNT_W-1:0] xfer_cnt2,
    output logic [COUNT_W-1:0] xfer_cnt3
`endif
);

    logic [3:0]       w_sel_oh;
    logic [3:0]       w_load;
    logic             w_in_ready;
    logic [WIDTH-1:0] w_dat [4];
`ifdef RESULT_DEMUX4_COUNT_EN
    logic [COUNT_W-1:0] w_cnt [4];
`endif

    assign w_sel_oh = sel_onehot(sel);

    // Ready depends only on the addressed slot: it can take a word if empty
    // or if it is being drained this same cycle.
    assign w_in_ready = !out_valid[sel] || out_ready[sel];
    assign w_load     = (in_valid && w_in_ready) ? w_sel_oh : 4'b0000;

    for (genvar k = 0; k < 4; k++) begin : g_slot
        demux_slot #(
            .WIDTH   (WIDTH)
`ifdef RESULT_DEMUX4_COUNT_EN
            ,
            .COUNT_W (COUNT_W)
`endif
        ) u_slot (
            .clk    (clk),
            .rst    (rst),
            .i_load (w_load[k]),
            .i_dat  (in_data),
            .i_rdy  (out_ready[k]),
            .o_vld  (out_valid[k]),
            .o_dat  (w_dat[k])
`ifdef RESULT_DEMUX4_COUNT_EN
            ,
            .o_cnt  (w_cnt[k])
`endif
        );
    end

    assign in_ready  = w_in_ready;
    assign out_data0 = w_dat[0];
    assign out_data1 = w_dat[1];
    assign out_data2 = w_dat[2];
    assign out_data3 = w_dat[3];
`ifdef RESULT_DEMUX4_COUNT_EN
    assign xfer_cnt0 = w_cnt[0];
    assign xfer_cnt1 = w_cnt[1];
    assign xfer_cnt2 = w_cnt[2];
    assign xfer_cnt3 = w_cnt[3];
`endif

endmodule

// File: tb/tb_result_demux4.sv
// Self-checking bench for result_demux4: directed scenarios plus a per-port scoreboard.
// Latency: n/a. Backpressure: driven directly through out_ready patterns.
// The counter scenario is built only when RESULT_DEMUX4_COUNT_EN is defined.
module tb_result_demux4;
    import result_demux4_pkg::*;

    localparam int W  = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [1:0]    sel;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready;
    logic [W-1:0]  out_data0, out_data1, out_data2, out_data3;
`ifdef RESULT_DEMUX4_COUNT_EN
    logic [CW-1:0] xfer_cnt0, xfer_cnt1, xfer_cnt2, xfer_cnt3;
`endif

    int checks = 0;
    int errors = 0;

    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    logic [W-1:0] q2[$];
    logic [W-1:0] q3[$];

    always #5 clk = ~clk;

    result_demux4 #(
        .WIDTH   (W)
`ifdef RESULT_DEMUX4_COUNT_EN
        ,
        .COUNT_W (CW)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .out_data3 (out_data3)
`ifdef RESULT_DEMUX4_COUNT_EN
        ,
        .xfer_cnt0 (xfer_cnt0),
        .xfer_cnt1 (xfer_cnt1),
        .xfer_cnt2 (xfer_cnt2),
        .xfer_cnt3 (xfer_cnt3)
`endif
    );

    function automatic logic [W-1:0] port_data(input int k);
        case (k)
            0:       return out_data0;
            1:       return out_data1;
            2:       return out_data2;
            default: return out_data3;
        endcase
    endfunction

    function automatic int q_size(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            2:       return q2.size();
            default: return q3.size();
        endcase
    endfunction

    // Scoreboard monitor: inputs change 1 time unit after posedge, so the
    // negedge sees exactly what the next posedge will commit. Drains are
    // popped before the same-cycle accept is pushed (front is the older word).
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 4; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    logic [W-1:0] exp_w;
                    checks++;
                    if (q_size(k) == 0) begin
                        errors++;
                        $display("FAIL sb_underflow port%0d: drained 0x%08h with nothing expected", k, port_data(k));
                    end else begin
                        case (k)
                            0:       exp_w = q0.pop_front();
                            1:       exp_w = q1.pop_front();
                            2:       exp_w = q2.pop_front();
                            default: exp_w = q3.pop_front();
                        endcase
                        if (port_data(k) !== exp_w) begin
                            errors++;
                            $display("FAIL sb_data port%0d: got 0x%08h expected 0x%08h", k, port_data(k), exp_w);
                        end
                    end
                end
            end
            // Reference acceptance rule for the selected port.
            if (in_valid && (!out_valid[sel] || out_ready[sel])) begin
                case (sel)
                    SEL_PORT0: q0.push_back(in_data);
                    SEL_PORT1: q1.push_back(in_data);
                    SEL_PORT2: q2.push_back(in_data);
                    default:   q3.push_back(in_data);
                endcase
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic flush_sb();
        q0.delete(); q1.delete(); q2.delete(); q3.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; sel = 2'd0; out_ready = 4'b0000;
        cyc(); cyc();
        checks++;
        if (out_valid !== 4'b0000) begin errors++; $display("FAIL reset_valid: got %b expected 0000", out_valid); end
        checks++;
        if ({out_data0, out_data1, out_data2, out_data3} !== '0) begin
            errors++; $display("FAIL reset_data: got %h %h %h %h expected all 0", out_data0, out_data1, out_data2, out_data3);
        end
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end

        // Fill slot 2 and hold it, then reset asynchronously mid-cycle.
        in_valid = 1'b1; sel = SEL_PORT2; in_data = 32'hCAFE_0002;
        cyc();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 4'b0100 || out_data2 !== 32'hCAFE_0002) begin
            errors++; $display("FAIL reset_prefill: got valid=%b data2=0x%08h expected 0100/0xcafe0002", out_valid, out_data2);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 4'b0000 || out_data2 !== '0) begin
            errors++; $display("FAIL reset_async: got valid=%b data2=0x%08h expected 0000/0", out_valid, out_data2);
        end
        flush_sb();
        cyc();
        rst = 1'b0;
        sel = SEL_PORT2;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_routing();
        out_ready = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            logic [W-1:0] exp_w;
            logic [3:0]   exp_v;
            exp_w = 32'hDEAD_0000 + W'(k);
            exp_v = 4'b0001 << k;
            in_valid = 1'b1; sel = 2'(k); in_data = exp_w;
            cyc();
            checks++;
            if (out_valid !== exp_v || port_data(k) !== exp_w) begin
                errors++; $display("FAIL routing port%0d: got valid=%b data=0x%08h expected %b/0x%08h", k, out_valid, port_data(k), exp_v, exp_w);
            end
        end
        in_valid = 1'b0;
        cyc();
        checks++;
        if (out_valid !== 4'b0000) begin errors++; $display("FAIL routing_idle: got %b expected 0000", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 4'b1101;
        in_valid = 1'b1; sel = SEL_PORT1; in_data = 32'h1111;
        cyc();
        in_data = 32'h2222;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_low: got %b expected 0", in_ready); end
        cyc();
        checks++;
        if (out_valid[1] !== 1'b1 || out_data1 !== 32'h1111) begin
            errors++; $display("FAIL bp_hold: got valid=%b data1=0x%08h expected 1/0x00001111", out_valid[1], out_data1);
        end
        out_ready = 4'b1111;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_high: got %b expected 1", in_ready); end
        cyc();
        in_valid = 1'b0;
        checks++;
        if (out_valid[1] !== 1'b1 || out_data1 !== 32'h2222) begin
            errors++; $display("FAIL bp_reload: got valid=%b data1=0x%08h expected 1/0x00002222", out_valid[1], out_data1);
        end
        cyc();
        checks++;
        if (out_valid !== 4'b0000) begin errors++; $display("FAIL bp_drained: got %b expected 0000", out_valid); end
    endtask

    task automatic test_independence();
        int delivered;
        out_ready = 4'b0000;
        in_valid = 1'b1; sel = SEL_PORT3; in_data = 32'h3333_3333;
        cyc();
        out_ready = 4'b0001;
        delivered = 0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; sel = SEL_PORT0; in_data = 32'h0000_0A00 + W'(i);
            #1;
            if (in_ready !== 1'b1) begin
                checks++; errors++; $display("FAIL indep_ready word%0d: got %b expected 1", i, in_ready);
            end
            cyc();
            if (out_valid[0] === 1'b1 && out_data0 === 32'h0000_0A00 + W'(i)) delivered++;
        end
        in_valid = 1'b0;
        cyc();
        checks++;
        if (delivered != 8) begin errors++; $display("FAIL indep_stream: got %0d words on time expected 8", delivered); end
        checks++;
        if (out_valid !== 4'b1000 || out_data3 !== 32'h3333_3333) begin
            errors++; $display("FAIL indep_port3: got valid=%b data3=0x%08h expected 1000/0x33333333", out_valid, out_data3);
        end
        out_ready = 4'b1000;
        cyc();
        out_ready = 4'b0000;
    endtask

    task automatic test_simultaneous();
        out_ready = 4'b0000;
        in_valid = 1'b1; sel = SEL_PORT2; in_data = 32'hA;
        cyc();
        out_ready = 4'b0100; in_data = 32'hB;
        cyc();
        in_valid = 1'b0;
        checks++;
        if (out_valid[2] !== 1'b1 || out_data2 !== 32'hB) begin
            errors++; $display("FAIL simul: got valid=%b data2=0x%08h expected 1/0x0000000b", out_valid[2], out_data2);
        end
        cyc();
        checks++;
        if (out_valid !== 4'b0000 || out_data2 !== 32'hB) begin
            errors++; $display("FAIL simul_drain: got valid=%b data2=0x%08h expected 0000/0x0000000b", out_valid, out_data2);
        end
        out_ready = 4'b0000;
    endtask

`ifdef RESULT_DEMUX4_COUNT_EN
    task automatic test_counter();
        logic [CW-1:0] exp_c;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        flush_sb();
        out_ready = 4'b0001;
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1; sel = SEL_PORT0; in_data = 32'h0C00 + W'(i);
            cyc();
        end
        in_valid = 1'b0;
        cyc();
        exp_c = CW'(17 % (1 << CW));
        checks++;
        if (xfer_cnt0 !== exp_c) begin errors++; $display("FAIL cnt_wrap: got %0d expected %0d", xfer_cnt0, exp_c); end
        checks++;
        if (xfer_cnt1 !== '0 || xfer_cnt2 !== '0 || xfer_cnt3 !== '0) begin
            errors++; $display("FAIL cnt_others: got %0d %0d %0d expected 0 0 0", xfer_cnt1, xfer_cnt2, xfer_cnt3);
        end
        out_ready = 4'b0000;
    endtask
`endif

    initial begin
        test_reset();
        test_routing();
        test_backpressure();
        test_independence();
        test_simultaneous();
`ifdef RESULT_DEMUX4_COUNT_EN
        test_counter();
`endif
        cyc();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (q_size(k) != 0) begin errors++; $display("FAIL sb_leftover port%0d: got %0d pending expected 0", k, q_size(k)); end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
